// File: rtl/pipelined_arith_elastic.sv
// pipelined_arith_elastic: 3-stage F = ((A+B)+(C-D))*D mod 2^N with valid/ready backpressure.
// Optional macro PIPELINED_ARITH_OVF_EN adds the registered multiply-overflow flag 'ovf'.
module pipelined_arith_elastic #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] F
`ifdef PIPELINED_ARITH_OVF_EN
    ,
    output logic         ovf
`endif
);

    logic         v1, v2, v3;
    logic         en1, en2, en3;
    logic [N-1:0] x1, x2, d1;
    logic [N-1:0] x3, d2;
    logic [N-1:0] p;

    // A stage may advance when it is empty or the stage below it is advancing.
    assign en3      = !v3 || out_ready;
    assign en2      = !v2 || en3;
    assign en1      = !v1 || en2;
    assign in_ready = en1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            x1 <= '0;
            x2 <= '0;
            d1 <= '0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                x1 <= A + B;
                x2 <= C - D;
                d1 <= D;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            x3 <= '0;
            d2 <= '0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                x3 <= x1 + x2;
                d2 <= d1;
            end
        end
    end

`ifdef PIPELINED_ARITH_OVF_EN
    logic [2*N-1:0] prod_full;
    logic           ovf_r;

    // Full-width product so the discarded upper half can be flagged.
    assign prod_full = {{N{1'b0}}, x3} * {{N{1'b0}}, d2};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3    <= 1'b0;
            p     <= '0;
            ovf_r <= 1'b0;
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                p     <= prod_full[N-1:0];
                ovf_r <= |prod_full[2*N-1:N];
            end
        end
    end

    assign ovf = ovf_r;
`else
    logic [N-1:0] prod_low;

    assign prod_low = x3 * d2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3 <= 1'b0;
            p  <= '0;
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                p <= prod_low;
            end
        end
    end
`endif

    assign F         = p;
    assign out_valid = v3;

endmodule

// File: tb/tb_pipelined_arith_elastic.sv
// Self-checking bench for pipelined_arith_elastic: directed plan steps followed by random traffic,
// compared against an occupancy/age scoreboard. Honours PIPELINED_ARITH_OVF_EN for the ovf port.
module tb_pipelined_arith_elastic;

    localparam int N    = 10;
    localparam int MASK = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A, B, C, D;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] F;
`ifdef PIPELINED_ARITH_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    pipelined_arith_elastic #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F)
`ifdef PIPELINED_ARITH_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Each in-flight result remembers how many clock edges it has been inside the pipe;
    // the oldest one is presented once it has had three edges.
    typedef struct {
        logic [N-1:0] f;
        logic         ov;
        int           age;
    } item_t;

    item_t pipeq[$];
    int    checks     = 0;
    int    errors     = 0;
    bit    known      = 1'b0;
    bit    afterReset = 1'b0;
    bit    lastInXfer = 1'b0;

    function automatic logic [N-1:0] refF(input int a, input int b, input int c, input int d);
        longint s;
        longint pr;
        s  = (longint'(a) + b) + (longint'(c) - d);
        pr = (s & MASK) * d;
        return pr[N-1:0];
    endfunction

    function automatic logic refOvf(input int a, input int b, input int c, input int d);
        longint s;
        longint pr;
        s  = (longint'(a) + b) + (longint'(c) - d);
        pr = (s & MASK) * d;
        return (pr >> N) != 0;
    endfunction

    function automatic bit modelOutValid();
        return (pipeq.size() > 0) && (pipeq[0].age >= 3);
    endfunction

    function automatic bit modelInReady(input bit ordy);
        return (pipeq.size() < 3) || ordy;
    endfunction

    task automatic checkOutput();
        bit expValid;
        bit expReady;
        expValid = modelOutValid();
        expReady = modelInReady(out_ready);
        checks++;
        assert (out_valid === expValid) else begin
            errors++;
            $error("[TB] FAIL out_valid observed=%b expected=%b", out_valid, expValid);
        end
        checks++;
        assert (in_ready === expReady) else begin
            errors++;
            $error("[TB] FAIL in_ready observed=%b expected=%b", in_ready, expReady);
        end
        if (expValid) begin
            checks++;
            assert (F === pipeq[0].f) else begin
                errors++;
                $error("[TB] FAIL F observed=%0d expected=%0d", F, pipeq[0].f);
            end
`ifdef PIPELINED_ARITH_OVF_EN
            checks++;
            assert (ovf === pipeq[0].ov) else begin
                errors++;
                $error("[TB] FAIL ovf observed=%b expected=%b", ovf, pipeq[0].ov);
            end
`endif
        end
        if (afterReset) begin
            checks++;
            assert (F === '0) else begin
                errors++;
                $error("[TB] FAIL F_reset observed=%0d expected=0", F);
            end
`ifdef PIPELINED_ARITH_OVF_EN
            checks++;
            assert (ovf === 1'b0) else begin
                errors++;
                $error("[TB] FAIL ovf_reset observed=%b expected=0", ovf);
            end
`endif
        end
    endtask

    // One clock cycle: drive, check at the falling edge, then advance the scoreboard.
    task automatic applyStimulus(input bit iv, input int a, input int b, input int c,
                                 input int d, input bit ordy, input bit rst);
        bit inX;
        bit outX;
        in_valid  = iv;
        A         = N'(a);
        B         = N'(b);
        C         = N'(c);
        D         = N'(d);
        out_ready = ordy;
        rst_n     = !rst;
        @(negedge clk);
        if (known) checkOutput();
        inX  = iv && modelInReady(ordy);
        outX = modelOutValid() && ordy;
        @(posedge clk);
        lastInXfer = 1'b0;
        if (rst) begin
            pipeq.delete();
            known      = 1'b1;
            afterReset = 1'b1;
        end else if (known) begin
            afterReset = 1'b0;
            if (outX) void'(pipeq.pop_front());
            foreach (pipeq[i]) pipeq[i].age++;
            if (inX) begin
                pipeq.push_back('{f: refF(a, b, c, d), ov: refOvf(a, b, c, d), age: 1});
                lastInXfer = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input int cycles, input bit ordy);
        for (int i = 0; i < cycles; i++)
            applyStimulus(1'b0, $urandom_range(0, MASK), $urandom_range(0, MASK),
                          $urandom_range(0, MASK), $urandom_range(0, MASK), ordy, 1'b0);
    endtask

    initial begin
        int k;

        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        A = '0; B = '0; C = '0; D = '0;
        #1;

        $display("[TB] reset and basic");
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        idle(1, 1'b1);
        applyStimulus(1'b1, 5, 3, 10, 4, 1'b1, 1'b0);
        idle(4, 1'b1);

        $display("[TB] wrap");
        applyStimulus(1'b1, 0, 0, 0, 1, 1'b1, 1'b0);
        idle(3, 1'b1);
        applyStimulus(1'b1, 100, 100, 20, 20, 1'b1, 1'b0);
        idle(4, 1'b1);

        $display("[TB] streaming");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, i, 0, i, 1, 1'b1, 1'b0);
        idle(4, 1'b1);

        $display("[TB] backpressure");
        k = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (k < 5) begin
                applyStimulus(1'b1, k + 1, 2 * k, 3 * k + 7, k + 2, cyc >= 5, 1'b0);
                if (lastInXfer) k++;
            end else begin
                idle(1, cyc >= 5);
            end
        end

        $display("[TB] bubble collapse");
        applyStimulus(1'b1, 11, 12, 13, 3, 1'b0, 1'b0);
        idle(1, 1'b0);
        applyStimulus(1'b1, 21, 22, 23, 5, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(4, 1'b1);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 40 + i, 7, 9, 6 + i, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
        idle(5, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, MASK), $urandom_range(0, MASK),
                          $urandom_range(0, MASK), $urandom_range(0, MASK),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
        end
        idle(6, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
